// File: rtl/seg8_pkg.sv
// Shared definitions for the 8-digit 7-segment scan reader: glyph codes,
// capture FSM states and the active-low digit-select decoder.
package seg8_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-high gfedcba glyphs, after inverting the bus
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] idx;
    } sel_t;

    // Legal only when exactly one select line is pulled low.
    function automatic sel_t onehot_low(input logic [7:0] drains);
        sel_t       r;
        logic [3:0] zeros;
        r     = '0;
        zeros = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (!drains[i]) begin
                zeros = zeros + 4'd1;
                r.idx = 3'(i);
            end
        end
        r.legal = (zeros == 4'd1);
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 7-segment glyph to hex nibble decoder; ok is low for any
// pattern that is not one of the sixteen hex glyphs.
module seg7_hex_dec
    import seg8_pkg::*;
(
    input  logic [6:0] glyph,
    output logic       ok,
    output logic [3:0] nibble
);

    always_comb begin
        ok     = 1'b1;
        nibble = 4'h0;
        case (glyph)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg8_capture.sv
// Watches a multiplexed 8-digit 7-segment scan, debounces each digit slot and
// republishes the displayed 32-bit word once every digit has been captured.
module seg8_capture
    import seg8_pkg::*;
#(
    parameter int SETTLE = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  drains,
    input  logic [7:0]  leds,
    output logic [31:0] data,
    output logic        valid,
    output logic        changed,
    output logic        err
);

    localparam logic [7:0] SET8 = 8'(SETTLE);

    logic [7:0]  drains_q;
    logic [7:0]  leds_q;
    state_t      state;
    state_t      state_nxt;
    logic [15:0] ref_pat;
    logic [15:0] ref_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [31:0] shadow;
    logic [31:0] shadow_nxt;
    logic [7:0]  mask;
    logic [7:0]  mask_nxt;

    logic [15:0] pat;
    sel_t        sel;
    logic [6:0]  glyph;
    logic        glyph_ok;
    logic [3:0]  nibble;
    logic        decode;
    logic        restart;
    logic        publish;

    assign pat     = {drains_q, leds_q};
    assign sel     = onehot_low(drains_q);
    assign glyph   = ~leds_q[6:0];
    assign publish = (mask == 8'hFF);

    seg7_hex_dec u_dec (
        .glyph  (glyph),
        .ok     (glyph_ok),
        .nibble (nibble)
    );

    // restart means "evaluate as a fresh pattern", shared by SCAN, a change
    // during SETTLE and any change while holding a decoded pattern.
    always_comb begin
        state_nxt = state;
        ref_nxt   = ref_pat;
        cnt_nxt   = cnt;
        decode    = 1'b0;
        restart   = 1'b0;
        case (state)
            ST_SCAN: restart = 1'b1;
            ST_SETTLE: begin
                if (pat == ref_pat) begin
                    if (cnt != SET8) begin
                        cnt_nxt = cnt + 8'd1;
                    end
                    if (cnt + 8'd1 == SET8) begin
                        decode    = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else begin
                    restart = 1'b1;
                end
            end
            ST_HOLD: begin
                if (pat != ref_pat) begin
                    restart = 1'b1;
                end
            end
            default: state_nxt = ST_SCAN;
        endcase

        if (restart) begin
            if (sel.legal) begin
                ref_nxt = pat;
                cnt_nxt = 8'd1;
                if (SET8 == 8'd1) begin
                    decode    = 1'b1;
                    state_nxt = ST_HOLD;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end else begin
                state_nxt = ST_SCAN;
            end
        end
    end

    // Publishing clears the mask first so a decode on the same edge starts
    // the next frame instead of being lost.
    always_comb begin
        mask_nxt   = publish ? 8'h00 : mask;
        shadow_nxt = shadow;
        if (decode && glyph_ok) begin
            mask_nxt[sel.idx]                    = 1'b1;
            shadow_nxt[{sel.idx, 2'b00} +: 4] = nibble;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drains_q <= SEG_BLANK;
            leds_q   <= SEG_BLANK;
            state    <= ST_SCAN;
            ref_pat  <= {SEG_BLANK, SEG_BLANK};
            cnt      <= 8'd0;
            shadow   <= 32'd0;
            mask     <= 8'd0;
            data     <= 32'd0;
            valid    <= 1'b0;
            changed  <= 1'b0;
            err      <= 1'b0;
        end else begin
            drains_q <= drains;
            leds_q   <= leds;
            state    <= state_nxt;
            ref_pat  <= ref_nxt;
            cnt      <= cnt_nxt;
            shadow   <= shadow_nxt;
            mask     <= mask_nxt;
            valid    <= publish;
            changed  <= publish && (shadow != data);
            err      <= decode && !glyph_ok;
            if (publish) begin
                data <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_seg8_capture.sv
// Bench for seg8_capture: directed scan scenarios plus random scans, each
// cycle compared against a run-length based behavioural model of the reader.
module tb_seg8_capture;

    localparam int SETTLE = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  drains;
    logic [7:0]  leds;
    logic [31:0] data;
    logic        valid;
    logic        changed;
    logic        err;

    seg8_capture #(.SETTLE(SETTLE)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .drains  (drains),
        .leds    (leds),
        .data    (data),
        .valid   (valid),
        .changed (changed),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: pattern seen next edge, run length of the current legal pattern
    logic [15:0] m_pq;
    logic [15:0] m_last;
    int          m_run;
    logic [31:0] m_shadow;
    logic [31:0] m_data;
    logic [7:0]  m_mask;
    logic        m_valid;
    logic        m_changed;
    logic        m_err;

    int          sec_valid;
    int          sec_err;
    logic [31:0] sec_data;
    logic        sec_changed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, want);
    endtask

    function automatic bit is_legal(input logic [7:0] d);
        return $countones(~d) == 1;
    endfunction

    function automatic int low_index(input logic [7:0] d);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) if (!d[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input int v);
        return {1'b1, ~glyph_tab[v]};
    endfunction

    task automatic m_edge(input logic r, input logic [15:0] in);
        logic [15:0] p;
        logic [6:0]  g;
        int          nib;
        int          dg;
        if (r) begin
            m_pq = 16'hFFFF; m_last = 16'h0; m_run = 0;
            m_shadow = 0; m_data = 0; m_mask = 0;
            m_valid = 0; m_changed = 0; m_err = 0;
            return;
        end
        p    = m_pq;
        m_pq = in;
        if (!is_legal(p[15:8])) m_run = 0;
        else if (m_run > 0 && p == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_last = p;
        m_valid   = (m_mask == 8'hFF);
        m_changed = m_valid && (m_shadow != m_data);
        if (m_valid) begin
            m_data = m_shadow;
            m_mask = 8'h00;
        end
        m_err = 0;
        if (m_run == SETTLE) begin
            g   = ~p[6:0];
            dg  = low_index(p[15:8]);
            nib = -1;
            for (int v = 0; v < 16; v++) if (glyph_tab[v] == g) nib = v;
            if (nib >= 0) begin
                m_shadow[4*dg +: 4] = 4'(nib);
                m_mask[dg] = 1'b1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic step_core(input logic [7:0] d, input logic [7:0] l, input logic r);
        @(negedge CLK);
        drains = d; leds = l; RST = r;
        @(posedge CLK);
        m_edge(r, {d, l});
        #1;
        chk("data", data, m_data);
        chk("valid", 32'(valid), 32'(m_valid));
        chk("changed", 32'(changed), 32'(m_changed));
        chk("err", 32'(err), 32'(m_err));
        chk("mask", 32'(dut.mask), 32'(m_mask));
        chk("shadow", dut.shadow, m_shadow);
        if (valid) begin
            sec_valid++;
            sec_data    = data;
            sec_changed = changed;
        end
        if (err) sec_err++;
    endtask

    task automatic step(input logic [7:0] d, input logic [7:0] l);
        step_core(d, l, 1'b0);
    endtask

    task automatic rst_cycle();
        step_core(8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic blank(input int n);
        repeat (n) step(8'hFF, 8'hFF);
    endtask

    task automatic show(input int dg, input int v, input int n);
        logic [7:0] s;
        s = 8'h01 << dg;
        repeat (n) step(~s, seg_of(v));
    endtask

    task automatic scan(input logic [31:0] word, input int n);
        for (int dg = 0; dg < 8; dg++) show(dg, int'(word[4*dg +: 4]), n);
    endtask

    task automatic clear_sec();
        sec_valid = 0; sec_err = 0; sec_data = 0; sec_changed = 0;
    endtask

    initial begin
        int          kind;
        int          len;
        int          dg;
        int          v;
        logic        dp;
        logic [7:0]  s;
        logic [7:0]  want_mask;

        drains = 8'hFF; leds = 8'hFF; RST = 1'b1;
        clear_sec();
        rst_cycle();
        rst_cycle();
        chk("rst_data", data, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_changed", 32'(changed), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Basic frame
        clear_sec();
        scan(32'h87654321, 10);
        blank(3);
        chk("basic_nvalid", sec_valid, 1);
        chk("basic_data", sec_data, 32'h87654321);
        chk("basic_changed", 32'(sec_changed), 32'h1);
        chk("basic_err", sec_err, 0);

        // Repeat frame, then one digit changed
        clear_sec();
        scan(32'h87654321, 10);
        blank(3);
        chk("repeat_nvalid", sec_valid, 1);
        chk("repeat_changed", 32'(sec_changed), 32'h0);
        clear_sec();
        scan(32'h8765A321, 10);
        blank(3);
        chk("digit3_data", sec_data, 32'h8765A321);
        chk("digit3_changed", 32'(sec_changed), 32'h1);

        // Glitch rejection and exact decode edge
        show(0, 5, 3);
        blank(4);
        chk("glitch_mask", 32'(dut.mask), 32'h0);
        show(0, 5, 4);
        chk("hold4_pre", 32'(dut.mask[0]), 32'h0);
        blank(1);
        chk("hold4_edge", 32'(dut.mask[0]), 32'h1);
        chk("hold4_nib", 32'(dut.shadow[3:0]), 32'h5);
        clear_sec();
        for (int d = 1; d < 8; d++) show(d, d + 8, 6);
        blank(3);
        chk("glitch_frame", sec_data, 32'hFEDCBA95);

        // Bad glyph on digit 2
        clear_sec();
        repeat (6) step(8'hFB, 8'hFE);
        blank(2);
        chk("bad_err", sec_err, 1);
        chk("bad_mask2", 32'(dut.mask[2]), 32'h0);
        scan(32'h98765021, 6);
        blank(3);
        chk("bad_nvalid", sec_valid, 1);
        chk("bad_data", sec_data, 32'h98765021);

        // Illegal selects interleaved
        clear_sec();
        for (int d = 0; d < 8; d++) begin
            show(d, 7 - d, 6);
            repeat (2) step(8'hFC, 8'($urandom));
            repeat (2) step(8'hFF, 8'hFF);
            if (d < 7) begin
                want_mask = 8'((1 << (d + 1)) - 1);
                chk("illegal_mask", 32'(dut.mask), 32'(want_mask));
            end
        end
        blank(2);
        chk("illegal_nvalid", sec_valid, 1);
        chk("illegal_data", sec_data, 32'h01234567);

        // Reset mid-frame
        for (int d = 0; d < 5; d++) show(d, d + 3, 6);
        rst_cycle();
        chk("midrst_data", data, 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_mask", 32'(dut.mask), 32'h0);
        clear_sec();
        scan(32'h2468ACE0, 6);
        blank(3);
        chk("midrst_nvalid", sec_valid, 1);
        chk("midrst_new", sec_data, 32'h2468ACE0);
        chk("midrst_changed", 32'(sec_changed), 32'h1);

        // Random scans
        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 99);
            len  = $urandom_range(1, 8);
            dp   = 1'($urandom_range(0, 1));
            dg   = $urandom_range(0, 7);
            s    = 8'h01 << dg;
            if (kind < 2) begin
                rst_cycle();
            end else if (kind < 12) begin
                repeat (len) step(8'($urandom), 8'($urandom));
            end else if (kind < 22) begin
                repeat (len) step(~s, {dp, 7'($urandom)});
            end else begin
                v = $urandom_range(0, 15);
                repeat (len) step(~s, {dp, ~glyph_tab[v]});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
